// File: rtl/matrix_mult_simple_mem.sv
// -----------------------------------------------------------------------------
// matrix_mult_simple_mem
//
// Standalone 4x4 unsigned matrix multiplier, C = A x B, working entirely out of
// on-chip register arrays. A and B are loaded with fixed constants by reset and
// have no external write path. C is filled by a single sequential
// multiply-accumulate engine, one MAC per clock. Results are read
// hierarchically from mem_c.
//
// All three arrays are row-major: element (row, col) sits at index 4*row+col.
//
// Parameters
//   DATA_W : width of each A/B element (unsigned)
//   ACC_W  : width of each C element and of the accumulator; wide enough for
//            a 4-term sum of DATA_W x DATA_W products
//
// Ports
//   clk    : single clock, all state updates on the rising edge
//   reset  : synchronous, active-high; reloads A/B, clears C, returns to IDLE
//   start  : begin one multiplication (sampled in IDLE and DONE only)
//   done   : registered completion flag, high from the final C write until
//            the next accepted start or reset
// -----------------------------------------------------------------------------
module matrix_mult_simple_mem #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Packed arrays so a whole-array reset load is a single assignment;
  // element indexing (mem_c[n]) works the same as for an unpacked array.
  logic [0:15][DATA_W-1:0] mem_a;
  logic [0:15][DATA_W-1:0] mem_b;
  logic [0:15][ACC_W-1:0]  mem_c;

  state_t           state;
  logic [1:0]       i;
  logic [1:0]       j;
  logic [1:0]       k;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;

  // A(r,c) = 4r+c+1 -> values 1..16
  function automatic logic [0:15][DATA_W-1:0] init_a();
    logic [0:15][DATA_W-1:0] m;
    for (int n = 0; n < 16; n++) begin
      m[n] = DATA_W'(n + 1);
    end
    return m;
  endfunction

  // B(r,c) = r+c -> values 0..6
  function automatic logic [0:15][DATA_W-1:0] init_b();
    logic [0:15][DATA_W-1:0] m;
    for (int n = 0; n < 16; n++) begin
      m[n] = DATA_W'((n / 4) + (n % 4));
    end
    return m;
  endfunction

  // Unsigned MAC at full accumulator width. Operands are zero-extended before
  // the multiply so the product is never truncated to DATA_W bits.
  function automatic logic [ACC_W-1:0] mac(
    input logic [ACC_W-1:0]  a_acc,
    input logic [DATA_W-1:0] a_op,
    input logic [DATA_W-1:0] b_op
  );
    return a_acc + (ACC_W'(a_op) * ACC_W'(b_op));
  endfunction

  // Operand fetch and MAC: A(i,k) * B(k,j); {i,k} and {k,j} form 4*row+col.
  always_comb begin
    acc_next = mac(acc, mem_a[{i, k}], mem_b[{k, j}]);
  end

  // Sequencer: k innermost, then j, then i. The k==3 MAC of each (i,j) pair
  // commits straight to mem_c and restarts the accumulator from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_a <= init_a();
      mem_b <= init_b();
      mem_c <= '0;
      acc   <= '0;
      i     <= 2'd0;
      j     <= 2'd0;
      k     <= 2'd0;
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            acc   <= '0;
            i     <= 2'd0;
            j     <= 2'd0;
            k     <= 2'd0;
          end
        end

        CALC: begin
          if (k == 2'd3) begin
            mem_c[{i, j}] <= acc_next;
            acc           <= '0;
            k             <= 2'd0;
            j             <= j + 2'd1;
            if (j == 2'd3) begin
              i <= i + 2'd1;
              // Last element (3,3) just committed.
              if (i == 2'd3) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end else begin
            acc <= acc_next;
            k   <= k + 2'd1;
          end
        end

        DONE: begin
          if (start) begin
            state <= CALC;
            done  <= 1'b0;
            acc   <= '0;
            i     <= 2'd0;
            j     <= 2'd0;
            k     <= 2'd0;
          end
        end

        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_simple_mem.sv
// -----------------------------------------------------------------------------
// tb_matrix_mult_simple_mem
//
// Self-checking bench for matrix_mult_simple_mem. Inputs are driven and
// outputs sampled on the falling edge, away from the active rising edge.
// Expected C entries come from the closed form C(i,j) = j(16i+10)+24i+20;
// they are queued when a run is started and popped as each write edge passes.
// -----------------------------------------------------------------------------
module tb_matrix_mult_simple_mem;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 2*DATA_W+2;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int               idx;
    logic [ACC_W-1:0] val;
  } exp_t;

  exp_t sb[$];

  matrix_mult_simple_mem #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .done (done)
  );

  always #5 clk = ~clk;

  function automatic logic [ACC_W-1:0] c_ref(input int r, input int c);
    return ACC_W'(c * (16 * r + 10) + 24 * r + 20);
  endfunction

  // Advance one cycle: through the rising edge, then to the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_c_clear(input string name);
    int bad_idx;
    bad_idx = -1;
    for (int n = 15; n >= 0; n--) begin
      if (dut.mem_c[n] !== '0) bad_idx = n;
    end
    tests++;
    if (bad_idx >= 0) begin
      fails++;
      $display("FAIL %s: mem_c[%0d] = %0d, expected 0", name, bad_idx, dut.mem_c[bad_idx]);
    end
  endtask

  // mode 0: single-cycle start pulse
  // mode 1: start toggled throughout CALC
  // mode 2: start held high, left high on exit (FSM restarts on next edge)
  // fresh : mem_c was all zero before this run, so unwritten entries must stay 0
  task automatic run(input int mode, input bit fresh, input string name);
    exp_t e;
    bit   early_done;
    int   m;
    early_done = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        e.idx = 4 * r + c;
        e.val = c_ref(r, c);
        sb.push_back(e);
      end
    end
    start = 1'b1;
    step();  // edge T: start sampled
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL %s done_after_start: done = %b, expected 0", name, done);
    end
    if (mode != 2) start = 1'b0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      if (mode == 1) start = (cyc % 2 == 1);
      step();  // edge T+cyc
      if (cyc % 4 == 0) begin
        m = cyc / 4 - 1;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL %s scoreboard_empty at cycle %0d", name, cyc);
        end else begin
          e = sb.pop_front();
          if (dut.mem_c[e.idx] !== e.val || e.idx != m) begin
            fails++;
            $display("FAIL %s mem_c[%0d] at T+%0d: got %0d, expected %0d", name, e.idx, cyc,
                     dut.mem_c[e.idx], e.val);
          end
        end
        if (fresh && m < 15) begin
          tests++;
          if (dut.mem_c[m+1] !== '0) begin
            fails++;
            $display("FAIL %s premature mem_c[%0d] at T+%0d: got %0d, expected 0", name, m + 1,
                     cyc, dut.mem_c[m+1]);
          end
        end
      end
      if (cyc < 64 && done !== 1'b0) early_done = 1'b1;
      if (cyc == 64) begin
        tests++;
        if (done !== 1'b1) begin
          fails++;
          $display("FAIL %s done_at_T+64: done = %b, expected 1", name, done);
        end
      end
    end
    tests++;
    if (early_done) begin
      fails++;
      $display("FAIL %s early_done: done = 1 before T+64, expected 0", name);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL %s scoreboard_left: %0d entries, expected 0", name, sb.size());
      sb.delete();
    end
    if (mode != 2) start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL reset_done: done = %b, expected 0", done);
    end
    check_c_clear("reset_mem_c");
    tests++;
    if (dut.mem_a[5] !== 8'd6 || dut.mem_a[15] !== 8'd16) begin
      fails++;
      $display("FAIL reset_mem_a: a[5]=%0d a[15]=%0d, expected 6 16", dut.mem_a[5], dut.mem_a[15]);
    end
    tests++;
    if (dut.mem_b[6] !== 8'd3 || dut.mem_b[15] !== 8'd6) begin
      fails++;
      $display("FAIL reset_mem_b: b[6]=%0d b[15]=%0d, expected 3 6", dut.mem_b[6], dut.mem_b[15]);
    end
  endtask

  task automatic test_idle();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (done !== 1'b0) seen = 1'b1;
    end
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL idle_done: done = 1 without start, expected 0");
    end
    check_c_clear("idle_mem_c");
  endtask

  task automatic test_single();
    do_reset();
    step();
    step();
    run(0, 1'b1, "single");
  endtask

  task automatic test_toggle();
    do_reset();
    run(1, 1'b1, "toggle");
  endtask

  task automatic test_reset_mid();
    do_reset();
    start = 1'b1;
    step();  // edge T
    start = 1'b0;
    for (int n = 0; n < 30; n++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_done: done = %b, expected 0", done);
    end
    check_c_clear("reset_mid_mem_c");
    run(0, 1'b1, "after_reset_mid");
  endtask

  task automatic test_rerun();
    tests++;
    if (dut.mem_c[15] !== 18'd266) begin
      fails++;
      $display("FAIL rerun_before: mem_c[15] = %0d, expected 266", dut.mem_c[15]);
    end
    run(0, 1'b0, "rerun");
  endtask

  task automatic test_back_to_back();
    run(2, 1'b0, "hold_first");
    run(0, 1'b0, "hold_second");
    for (int n = 0; n < 5; n++) step();
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL done_hold: done = %b, expected 1", done);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_idle();
    test_single();
    test_toggle();
    test_reset_mid();
    test_rerun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
